aes_inv_cipher: RTL
===================

# aes_inv_cipher

Iterative AES-128 inverse cipher (FIPS-197 InvCipher). It computes one inverse round per clock and turns a 128-bit ciphertext block into plaintext in 10 cycles. It is the decrypt-side counterpart of the forward round datapath. Round keys come from an external key store, which is indexed combinationally by `rk_idx`. Byte order matches the forward path: internal byte i is FIPS state byte i and sits at bits [8*i +: 8], so FIPS hex strings must be byte-swapped.

## Interface
Parameters: none (AES-128 only, Nr = 10 fixed).

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request; sampled only while `busy`=0
- `ct_in`  in  128  ciphertext, internal byte order; sampled on the accepting edge
- `rk_idx`  out  4  round-key index requested this cycle (0..10)
- `rk_in`  in  128  round key `rk_idx`, internal order; must be valid in the same cycle (combinational lookup)
- `busy`  out  1  high while a block is in flight
- `done`  out  1  one-cycle pulse; `pt_out` is valid from this cycle on
- `pt_out`  out  128  plaintext, internal order; held until the next completion

## Operation
- States: IDLE and RUN. Round counter `r` is 4 bits.
- IDLE:
  - `rk_idx`=10.
  - On `start`=1 at an edge: `state` <= `ct_in` ^ `rk_in` (initial AddRoundKey with key 10), `r` <= 9, `busy` <= 1, go to RUN.
- RUN:
  - `rk_idx`=`r`.
  - Each edge: `state` <= InvRound(`state`, `rk_in`, `r`==0).
  - InvRound applies, in order: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns only when `r`≠0.
  - When `r`≠0: `r` <= `r`-1.
  - When `r`=0: `pt_out` <= result, `done` <= 1, `busy` <= 0, go to IDLE.
- InvShiftRows: row k (bytes at index ≡ k mod 4) rotates right by k columns. Output byte i takes input byte (i - 4k) mod 16, where k = i mod 4.
- InvSubBytes is computed arithmetically; there is no 256-entry table.
  - Inverse affine: b' = rotl(b,1) ^ rotl(b,3) ^ rotl(b,6) ^ 8'h05.
  - Then multiplicative inverse in GF(2^8) mod x^8+x^4+x^3+x+1, with inv(0)=0.
- InvMixColumns: per column, coefficients {0e,0b,0d,09} in a circulant arrangement, built from xtime chains. All byte arithmetic is 8-bit with XOR.
- `start` while `busy`=1 is ignored. No queueing, and `ct_in` is not re-sampled.
- `done` is 0 in every cycle except the one after the final-round edge.

## Timing
- Reset (async, immediate): state IDLE, `busy`=0, `done`=0, `pt_out`=0, internal `state`=0, `r`=0, `rk_idx`=10.
- Reset asserted mid-block aborts the block. No `done` pulse is produced, and outputs return to reset values at once.
- Latency: `start` accepted at edge E0. Rounds 9..1 run at E1..E9 and round 0 at E10. `done`=1 and the new `pt_out` are visible in the cycle after E10.
- `busy` rises after E0 and falls after E10.
- Back-to-back: `start`=1 in the `done` cycle is accepted at the next edge, since the block is already in IDLE. Sustained throughput is one block per 11 cycles.
- `rk_idx` is a pure function of state and `r`, so it is glitch-free relative to `clk`. The key store has the full cycle to return `rk_in`.
- `pt_out` changes only at a completion edge or on reset.

## Test plan
- FIPS-197 App. C.1: key 000102…0f, `ct_in`=bswap(69c4e0d86a7b0430d8cdb78070b4c55a), start pulse. Expected: `done` exactly 11 edges after the start edge (count E0), and bswap(`pt_out`)=00112233445566778899aabbccddeeff. The bench key model supplies rk[10]=13111d7fe3944a17f307a78b4d2b30c5 and rk[1]=d6aa74fdd2af72fadaa678f1d6ab76fe (both byte-swapped).
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32. Expected plaintext 3243f6a8885a308d313198a2e0370734.
- `rk_idx` sequence check: after start, `rk_idx` reads 10 (IDLE), 9, 8, …, 0, then 10. Exactly one `done` pulse; `busy` high for exactly 10 cycles.
- Busy rejection and back-to-back:
  - Pulse `start` with a different `ct_in` at E5. Expected: ignored; result still equals the C.1 plaintext.
  - Assert `start` in the `done` cycle with the App. B vector. Expected: second result correct, its `done` 11 cycles later.
- Reset mid-operation: assert `rst` between E4 and E5. Expected: `busy`/`done`/`pt_out` go to 0 immediately and `rk_idx`=10. A subsequent C.1 run completes correctly.
- Idle stability: with `start`=0 for 20 cycles after a completion, `pt_out` holds its value and `done` stays 0.

Source files
------------

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher: one InvRound per clock, 10 rounds per block.
// Round keys are fetched combinationally from an external key store via rk_idx.
module aes_inv_cipher (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] ct_in,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] pt_out
);

    localparam int unsigned BLK_W = 128;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned NR    = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_e;

    fsm_e             fsm_q;
    logic [BLK_W-1:0] state_q;
    logic [BLK_W-1:0] state_d;
    logic [BLK_W-1:0] round_out;
    logic [CNT_W-1:0] r_q;
    logic             busy_q;
    logic             done_q;
    logic [BLK_W-1:0] pt_q;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 via square-and-multiply; maps 0 to 0 without a special case.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] y;
        logic [7:0] s;
        y = 8'h01;
        s = x;
        for (int k = 1; k < 8; k++) begin
            s = gf_mul(s, s);
            y = gf_mul(y, s);
        end
        return y;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(a);
    endfunction

    function automatic logic [BLK_W-1:0] inv_shift_rows(input logic [BLK_W-1:0] s);
        logic [BLK_W-1:0] o;
        int unsigned      src;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            src = (32'(i) + 32'd16 - 32'd4 * (32'(i) % 32'd4)) % 32'd16;
            o[8*i +: 8] = s[8*src +: 8];
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0]  a  [4];
        logic [7:0]  m9 [4];
        logic [7:0]  mb [4];
        logic [7:0]  md [4];
        logic [7:0]  me [4];
        logic [7:0]  x2, x4, x8;
        logic [31:0] o;
        for (int j = 0; j < 4; j++) begin
            a[j]  = c[8*j +: 8];
            x2    = xtime(a[j]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[j] = x8 ^ a[j];
            mb[j] = x8 ^ x2 ^ a[j];
            md[j] = x8 ^ x4 ^ a[j];
            me[j] = x8 ^ x4 ^ x2;
        end
        o = '0;
        for (int j = 0; j < 4; j++) begin
            o[8*j +: 8] = me[j] ^ mb[(j + 1) % 4] ^ md[(j + 2) % 4] ^ m9[(j + 3) % 4];
        end
        return o;
    endfunction

    function automatic logic [BLK_W-1:0] inv_round(input logic [BLK_W-1:0] s,
                                                   input logic [BLK_W-1:0] k,
                                                   input logic             last);
        logic [BLK_W-1:0] t;
        logic [BLK_W-1:0] u;
        t = inv_shift_rows(s);
        for (int i = 0; i < 16; i++) begin
            u[8*i +: 8] = inv_sbox(t[8*i +: 8]);
        end
        u = u ^ k;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                u[32*c +: 32] = inv_mix_col(u[32*c +: 32]);
            end
        end
        return u;
    endfunction

    // Next state: initial AddRoundKey when idle, a full inverse round when running.
    always_comb begin
        round_out = inv_round(state_q, rk_in, r_q == '0);
        state_d   = (fsm_q == IDLE) ? (ct_in ^ rk_in) : round_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (start) begin
                        state_q <= state_d;
                        r_q     <= CNT_W'(NR - 1);
                        busy_q  <= 1'b1;
                        fsm_q   <= RUN;
                    end
                end
                RUN: begin
                    state_q <= state_d;
                    if (r_q != '0) begin
                        r_q <= r_q - CNT_W'(1);
                    end else begin
                        pt_q   <= state_d;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        fsm_q  <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    // Key index depends only on registered state, so the key store sees a stable address.
    assign rk_idx = (fsm_q == RUN) ? r_q : CNT_W'(NR);
    assign busy   = busy_q;
    assign done   = done_q;
    assign pt_out = pt_q;

endmodule
